// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'b0;
  localparam logic [3:0]  REG_PC    = 4'hF;

endpackage

// File: rtl/hazard_lu_detect.sv
// Combinational load-use comparator: flags an ID-stage read of a register
// that the LDR currently in EX has not yet produced.
module hazard_lu_detect
  import hazard_pkg::*;
#(
  parameter int REG_W = 4
) (
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             id_use_rd,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_reg_write,
  output logic             lu
);

  // A load targeting the PC is handled as a branch elsewhere, never a stall.
  localparam logic [REG_W-1:0] PC_IDX = REG_W'(REG_PC);

  logic hit_rn, hit_rm, hit_rd;

  always_comb begin
    hit_rn = id_use_rn && (id_rn == ex_rd);
    hit_rm = id_use_rm && (id_rm == ex_rd);
    hit_rd = id_use_rd && (id_rd == ex_rd);
    lu     = ex_is_load && ex_reg_write && (ex_rd != PC_IDX) &&
             (hit_rn || hit_rm || hit_rd);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage ARM core: stalls, flushes and memory freezes.
// Optional perf counters are enabled by defining HAZ_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_LAT = 3,
  parameter int REG_W   = 4
`ifdef HAZ_PERF_CNT_EN
  ,
  parameter int CNT_W   = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             id_use_rd,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_reg_write,
  input  logic             ex_branch_taken,
  input  logic             mem_access,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             if_id_flush,
  output logic             id_ex_enable,
  output logic             id_ex_bubble,
  output logic             ex_mem_enable,
  output logic             mem_wb_bubble,
  output logic             busy_state
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
`endif
);

  localparam bit FREEZE_EN = (MEM_LAT > 1);
  localparam int WC_W      = $clog2(MEM_LAT + 1);
  localparam int WAIT_INIT = (MEM_LAT > 2) ? (MEM_LAT - 2) : 0;

  logic lu;

  hazard_lu_detect #(
    .REG_W(REG_W)
  ) u_lu_detect (
    .id_rn       (id_rn),
    .id_rm       (id_rm),
    .id_rd       (id_rd),
    .id_use_rn   (id_use_rn),
    .id_use_rm   (id_use_rm),
    .id_use_rd   (id_use_rd),
    .ex_rd       (ex_rd),
    .ex_is_load  (ex_is_load),
    .ex_reg_write(ex_reg_write),
    .lu          (lu)
  );

  state_e          state_reg, state_next;
  logic [WC_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic            stall_cyc, flush_cyc, freeze_cyc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= RUN;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_enable  = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_enable = 1'b1;
    mem_wb_bubble = 1'b0;
    busy_state    = 1'b0;
    stall_cyc     = 1'b0;
    flush_cyc     = 1'b0;
    freeze_cyc    = 1'b0;

    case (state_reg)
      RUN: begin
        if (mem_access && FREEZE_EN) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = WC_W'(WAIT_INIT);
          pc_enable     = 1'b0;
          if_id_enable  = 1'b0;
          id_ex_enable  = 1'b0;
          ex_mem_enable = 1'b0;
          mem_wb_bubble = 1'b1;
          freeze_cyc    = 1'b1;
        end else if (ex_branch_taken) begin
          if_id_flush   = 1'b1;
          id_ex_bubble  = 1'b1;
          flush_cyc     = 1'b1;
        end else if (lu) begin
          pc_enable     = 1'b0;
          if_id_enable  = 1'b0;
          id_ex_bubble  = 1'b1;
          stall_cyc     = 1'b1;
        end
      end
      MEM_WAIT: begin
        pc_enable     = 1'b0;
        if_id_enable  = 1'b0;
        id_ex_enable  = 1'b0;
        ex_mem_enable = 1'b0;
        mem_wb_bubble = 1'b1;
        busy_state    = 1'b1;
        freeze_cyc    = 1'b1;
        // Branch/load-use inputs are deliberately ignored: EX is frozen and
        // they are re-evaluated once the pipe is released.
        if (wait_cnt_reg == '0) begin
          state_next = RUN;
        end else begin
          wait_cnt_next = wait_cnt_reg - WC_W'(1);
        end
      end
      default: state_next = RUN;
    endcase

    if (reset) begin
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_enable  = 1'b0;
      id_ex_bubble  = 1'b1;
      ex_mem_enable = 1'b0;
      mem_wb_bubble = 1'b1;
      busy_state    = 1'b0;
      stall_cyc     = 1'b0;
      flush_cyc     = 1'b0;
      freeze_cyc    = 1'b0;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg, freeze_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg  <= '0;
      flush_cnt_reg  <= '0;
      freeze_cnt_reg <= '0;
    end else begin
      if (stall_cyc)  stall_cnt_reg  <= stall_cnt_reg + CNT_W'(1);
      if (flush_cyc)  flush_cnt_reg  <= flush_cnt_reg + CNT_W'(1);
      if (freeze_cyc) freeze_cnt_reg <= freeze_cnt_reg + CNT_W'(1);
    end
  end

  assign stall_cnt  = stall_cnt_reg;
  assign flush_cnt  = flush_cnt_reg;
  assign freeze_cnt = freeze_cnt_reg;
`else
  // Cycle classification only feeds the optional counters.
  logic unused_cyc;
  assign unused_cyc = stall_cyc ^ flush_cyc ^ freeze_cyc;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus random
// traffic compared each cycle against a behavioural model of the sequencing rules.
module tb_pipeline_hazard_ctrl;

  localparam int MEM_LAT = 3;
  localparam int REG_W   = 4;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [REG_W-1:0] id_rn, id_rm, id_rd, ex_rd;
  logic             id_use_rn, id_use_rm, id_use_rd;
  logic             ex_is_load, ex_reg_write, ex_branch_taken, mem_access;
  logic             pc_enable, if_id_enable, if_id_flush, id_ex_enable;
  logic             id_ex_bubble, ex_mem_enable, mem_wb_bubble, busy_state;
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;
`endif

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .MEM_LAT(MEM_LAT),
    .REG_W  (REG_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .id_rn          (id_rn),
    .id_rm          (id_rm),
    .id_rd          (id_rd),
    .id_use_rn      (id_use_rn),
    .id_use_rm      (id_use_rm),
    .id_use_rd      (id_use_rd),
    .ex_rd          (ex_rd),
    .ex_is_load     (ex_is_load),
    .ex_reg_write   (ex_reg_write),
    .ex_branch_taken(ex_branch_taken),
    .mem_access     (mem_access),
    .pc_enable      (pc_enable),
    .if_id_enable   (if_id_enable),
    .if_id_flush    (if_id_flush),
    .id_ex_enable   (id_ex_enable),
    .id_ex_bubble   (id_ex_bubble),
    .ex_mem_enable  (ex_mem_enable),
    .mem_wb_bubble  (mem_wb_bubble),
    .busy_state     (busy_state)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt),
    .freeze_cnt     (freeze_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: number of frozen MEM_WAIT cycles still to come.
  int m_freeze_left = 0;
  int m_stall = 0, m_flush = 0, m_freeze = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_lu();
    logic [REG_W-1:0] src [3];
    bit               used[3];
    src[0] = id_rn; src[1] = id_rm; src[2] = id_rd;
    used[0] = id_use_rn; used[1] = id_use_rm; used[2] = id_use_rd;
    if (!(ex_is_load && ex_reg_write) || ex_rd == 4'd15) return 1'b0;
    for (int i = 0; i < 3; i++)
      if (used[i] && src[i] == ex_rd) return 1'b1;
    return 1'b0;
  endfunction

  // Output vector: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_bubble, busy}
  typedef enum int {K_RESET, K_WAIT, K_FREEZE, K_BRANCH, K_STALL, K_NORMAL} kind_e;

  function automatic kind_e model_kind();
    if (reset) return K_RESET;
    if (m_freeze_left > 0) return K_WAIT;
    if (mem_access && MEM_LAT > 1) return K_FREEZE;
    if (ex_branch_taken) return K_BRANCH;
    if (model_lu()) return K_STALL;
    return K_NORMAL;
  endfunction

  function automatic logic [7:0] model_vec(input kind_e k);
    case (k)
      K_RESET:  return 8'b0010_1010;
      K_WAIT:   return 8'b0000_0011;
      K_FREEZE: return 8'b0000_0010;
      K_BRANCH: return 8'b1111_1100;
      K_STALL:  return 8'b0001_1100;
      default:  return 8'b1101_0100;
    endcase
  endfunction

  task automatic step(input string tag);
    kind_e      k;
    logic [7:0] obs;
    @(negedge clk);
    k   = model_kind();
    obs = {pc_enable, if_id_enable, if_id_flush, id_ex_enable,
           id_ex_bubble, ex_mem_enable, mem_wb_bubble, busy_state};
    check_eq(tag, {24'd0, obs}, {24'd0, model_vec(k)});
`ifdef HAZ_PERF_CNT_EN
    check_eq({tag, "_stall_cnt"},  {16'd0, stall_cnt},  m_stall);
    check_eq({tag, "_flush_cnt"},  {16'd0, flush_cnt},  m_flush);
    check_eq({tag, "_freeze_cnt"}, {16'd0, freeze_cnt}, m_freeze);
`endif
    $display("[TB] %-10s rst=%0b mem=%0b br=%0b lu=%0b out=%08b", tag, reset, mem_access,
             ex_branch_taken, model_lu(), obs);
    @(posedge clk);
    if (reset) begin
      m_freeze_left = 0;
      m_stall = 0; m_flush = 0; m_freeze = 0;
    end else begin
      if (k == K_STALL)  m_stall  = (m_stall + 1) % (1 << CNT_W);
      if (k == K_BRANCH) m_flush  = (m_flush + 1) % (1 << CNT_W);
      if (k == K_WAIT || k == K_FREEZE) m_freeze = (m_freeze + 1) % (1 << CNT_W);
      if (m_freeze_left > 0) m_freeze_left--;
      else if (k == K_FREEZE) m_freeze_left = MEM_LAT - 1;
    end
    #1;
  endtask

  task automatic idle();
    reset = 1'b0;
    id_rn = '0; id_rm = '0; id_rd = '0; ex_rd = '0;
    id_use_rn = 1'b0; id_use_rm = 1'b0; id_use_rd = 1'b0;
    ex_is_load = 1'b0; ex_reg_write = 1'b0;
    ex_branch_taken = 1'b0; mem_access = 1'b0;
  endtask

  task automatic set_lu(input logic [REG_W-1:0] rd);
    ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_rd = rd;
    id_rn = 4'd3; id_use_rn = 1'b1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    // 1: reset held two cycles, then idle run
    step("reset0");
    step("reset1");
    idle();
    step("idle");
    check_eq("idle_pc_en", {31'd0, pc_enable}, 32'd1);

    // 2: load-use stall for one cycle, then PC-destination load does not stall
    set_lu(4'd3);
    step("lu_stall");
    idle();
    step("lu_after");
    check_eq("lu_after_pc_en", {31'd0, pc_enable}, 32'd1);
    set_lu(4'd15);
    id_rn = 4'd15;
    step("lu_pc");
    idle();

    // 3: branch wins over load-use
    set_lu(4'd3);
    ex_branch_taken = 1'b1;
    step("br_vs_lu");
    idle();

    // 4: single-cycle memory access freezes for MEM_LAT cycles
    mem_access = 1'b1;
    step("frz0");
    mem_access = 1'b0;
    step("frz1");
    step("frz2");
    step("frz_rel");

    // 5: branch held through a freeze fires only after release
    mem_access = 1'b1;
    ex_branch_taken = 1'b1;
    step("frzbr0");
    mem_access = 1'b0;
    step("frzbr1");
    step("frzbr2");
    step("frzbr_rel");
    check_eq("frzbr_rel_flush", {31'd0, if_id_flush}, 32'd1);
    idle();

    // 6: reset in the middle of a wait aborts it
    mem_access = 1'b1;
    step("abort0");
    mem_access = 1'b0;
    step("abort1");
    reset = 1'b1;
    step("abort_rst");
    reset = 1'b0;
    step("abort_run");
    check_eq("abort_busy", {31'd0, busy_state}, 32'd0);

    // Random traffic
    for (int t = 0; t < 400; t++) begin
      reset           = ($urandom_range(0, 99) < 2);
      id_rn           = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      id_rm           = 4'($urandom_range(0, 3));
      id_rd           = 4'($urandom_range(0, 3));
      ex_rd           = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      id_use_rn       = 1'($urandom_range(0, 1));
      id_use_rm       = 1'($urandom_range(0, 1));
      id_use_rd       = 1'($urandom_range(0, 1));
      ex_is_load      = 1'($urandom_range(0, 1));
      ex_reg_write    = ($urandom_range(0, 3) != 0);
      ex_branch_taken = ($urandom_range(0, 99) < 15);
      mem_access      = ($urandom_range(0, 99) < 12);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
